// File: rtl/crossbar_arbiter_if.sv
// crossbar_arbiter_if: request/command and ownership signals between the crossbar controller and the arbiter
interface crossbar_arbiter_if;
    logic [15:0] request;
    logic        set_owner;
    logic        clr_owner;
    logic [15:0] grant;
    logic [3:0]  owner_id;
    logic        owner_valid;
    logic        hold_timeout;
    logic        protocol_err;
    modport master (
        output request, set_owner, clr_owner,
        input  grant, owner_id, owner_valid, hold_timeout, protocol_err
    );
    modport slave (
        input  request, set_owner, clr_owner,
        output grant, owner_id, owner_valid, hold_timeout, protocol_err
    );
endinterface

// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: controller-commanded round-robin bus ownership with hold timeout and sticky protocol error
module crossbar_arbiter #(
    parameter int MAX_HOLD = 256
) (
    input logic clk,
    input logic rst,
    crossbar_arbiter_if.slave bus
);
    localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD);
    logic [3:0]  ptr, win, idx;
    logic        found;
    logic [15:0] grant, hold_cnt;
    logic [3:0]  owner_id;
    logic        owner_valid, protocol_err;
    // first requester at or after ptr, wrapping mod 16
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && bus.request[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    // ownership, pointer, hold counter and error flag; clr_owner always wins over set_owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
            owner_id <= '0;
            owner_valid <= 1'b0;
            ptr <= '0;
            hold_cnt <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (owner_valid && hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 16'd1;
            if (bus.clr_owner) begin
                grant <= '0;
                owner_id <= '0;
                owner_valid <= 1'b0;
                hold_cnt <= '0;
                if (bus.set_owner || !owner_valid)
                    protocol_err <= 1'b1;
            end else if (bus.set_owner) begin
                if (owner_valid)
                    protocol_err <= 1'b1;
                else if (found) begin
                    grant <= 16'd1 << win;
                    owner_id <= win;
                    owner_valid <= 1'b1;
                    ptr <= win + 4'd1;
                    hold_cnt <= 16'd1;
                end
            end
        end
    end
    assign bus.grant = grant;
    assign bus.owner_id = owner_id;
    assign bus.owner_valid = owner_valid;
    assign bus.hold_timeout = owner_valid && hold_cnt == HOLD_MAX;
    assign bus.protocol_err = protocol_err;
endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb_crossbar_arbiter: directed stimulus with a cycle-tagged expectation queue checked by an independent monitor
module tb_crossbar_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    crossbar_arbiter_if bus();
    crossbar_arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] g;
        logic [3:0]  id;
        logic        v;
        logic        to;
        logic        e;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    event  chk_now;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every expectation whose cycle has been reached
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
                exp_t  x;
                string n;
                logic [22:0] act, req;
                x = exp_q.pop_front();
                n = name_q.pop_front();
                act = {bus.grant, bus.owner_id, bus.owner_valid, bus.hold_timeout, bus.protocol_err};
                req = {x.g, x.id, x.v, x.to, x.e};
                checks++;
                if (act !== req) begin
                    failures++;
                    $display("FAIL %s: got grant=%h id=%0d valid=%b to=%b err=%b, want grant=%h id=%0d valid=%b to=%b err=%b",
                             n, act[22:7], act[6:3], act[2], act[1], act[0],
                             req[22:7], req[6:3], req[2], req[1], req[0]);
                end
            end
        end
    end

    task automatic push(input int c, input [15:0] g, input [3:0] id, input v, input to, input e, input string n);
        exp_t x;
        x.cyc = 32'(c);
        x.g = g;
        x.id = id;
        x.v = v;
        x.to = to;
        x.e = e;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    // drive one cycle of inputs; expectation applies after the next rising edge
    task automatic step(input [15:0] r, input s, input c, input [15:0] g, input [3:0] id,
                        input v, input to, input e, input string n);
        @(posedge clk);
        #1;
        bus.request = r;
        bus.set_owner = s;
        bus.clr_owner = c;
        push(cyc + 1, g, id, v, to, e, n);
    endtask

    // asynchronous reset pulse inside the low clock phase, checked before any edge
    task automatic do_reset(input string n);
        @(posedge clk);
        @(negedge clk);
        bus.request = '0;
        bus.set_owner = 1'b0;
        bus.clr_owner = 1'b0;
        #2 rst = 1'b1;
        #1;
        push(cyc, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, n);
        ->chk_now;
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.request = '0;
        bus.set_owner = 1'b0;
        bus.clr_owner = 1'b0;
        do_reset("reset_state");
        // round robin basics and hold timeout
        step(16'h0011, 1, 0, 16'h0001, 4'd0, 1, 0, 0, "rr_first");
        step(16'h0011, 0, 0, 16'h0001, 4'd0, 1, 0, 0, "rr_hold");
        step(16'h0011, 0, 1, 16'h0000, 4'd0, 0, 0, 0, "rr_clr");
        step(16'h0011, 1, 0, 16'h0010, 4'd4, 1, 0, 0, "rr_second");
        step(16'h0000, 0, 0, 16'h0010, 4'd4, 1, 0, 0, "hold_req_drop");
        step(16'h0000, 0, 0, 16'h0010, 4'd4, 1, 0, 0, "hold_t3");
        step(16'h0000, 0, 0, 16'h0010, 4'd4, 1, 1, 0, "timeout_on");
        step(16'h0000, 0, 0, 16'h0010, 4'd4, 1, 1, 0, "timeout_stays");
        step(16'h0000, 0, 1, 16'h0000, 4'd0, 0, 0, 0, "timeout_release");
        step(16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0, 0, "idle_after_release");
        // wrap-around of the pointer
        step(16'h8000, 1, 0, 16'h8000, 4'd15, 1, 0, 0, "wrap_m15");
        step(16'h8001, 0, 1, 16'h0000, 4'd0, 0, 0, 0, "wrap_clr");
        step(16'h8001, 1, 0, 16'h0001, 4'd0, 1, 0, 0, "wrap_m0");
        step(16'h0000, 0, 1, 16'h0000, 4'd0, 0, 0, 0, "wrap_clr2");
        // set with no requests leaves pointer alone
        do_reset("reset_noreq");
        step(16'h0011, 1, 0, 16'h0001, 4'd0, 1, 0, 0, "noreq_pre");
        step(16'h0011, 0, 1, 16'h0000, 4'd0, 0, 0, 0, "noreq_clr");
        step(16'h0000, 1, 0, 16'h0000, 4'd0, 0, 0, 0, "set_noreq");
        step(16'h0011, 1, 0, 16'h0010, 4'd4, 1, 0, 0, "noreq_ptr_kept");
        // protocol errors
        do_reset("reset_err1");
        step(16'h0001, 1, 1, 16'h0000, 4'd0, 0, 0, 1, "set_and_clr");
        step(16'h0001, 0, 0, 16'h0000, 4'd0, 0, 0, 1, "err_sticky");
        do_reset("reset_err2");
        step(16'h0002, 1, 0, 16'h0002, 4'd1, 1, 0, 0, "own_m1");
        step(16'h0004, 1, 0, 16'h0002, 4'd1, 1, 0, 1, "set_while_own");
        do_reset("reset_err3");
        step(16'h0000, 0, 1, 16'h0000, 4'd0, 0, 0, 1, "clr_idle");
        // async reset during ownership, then normal operation
        do_reset("reset_err4");
        step(16'h0004, 1, 0, 16'h0004, 4'd2, 1, 0, 0, "own_m2");
        step(16'h0004, 0, 0, 16'h0004, 4'd2, 1, 0, 0, "own_m2_hold");
        do_reset("async_reset_mid_own");
        step(16'h0008, 1, 0, 16'h0008, 4'd3, 1, 0, 0, "post_reset_set");
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
